// File: rtl/conv_operand_feeder_if.sv
// Operand-feeder bus: host push channels for IFM/weight words and the
// accelerator-facing show-ahead heads with their read strobes.
interface conv_operand_feeder_if #(
   parameter int IFM_W = 64,
   parameter int WGT_W = 32
);
   logic [IFM_W-1:0] host_ifm_data;
   logic             host_ifm_valid;
   logic             host_ifm_ready;
   logic [WGT_W-1:0] host_wgt_data;
   logic             host_wgt_valid;
   logic             host_wgt_ready;
   logic [IFM_W-1:0] ifm;
   logic [WGT_W-1:0] weight;
   logic             ifm_read;
   logic             wgt_read;

   modport slave (
      input  host_ifm_data, host_ifm_valid, host_wgt_data, host_wgt_valid,
      input  ifm_read, wgt_read,
      output host_ifm_ready, host_wgt_ready, ifm, weight
   );

   modport master (
      output host_ifm_data, host_ifm_valid, host_wgt_data, host_wgt_valid,
      output ifm_read, wgt_read,
      input  host_ifm_ready, host_wgt_ready, ifm, weight
   );
endinterface

// File: rtl/conv_operand_feeder.sv
// Operand feeder: two show-ahead FIFOs (IFM, weight) plus a job sequencer
// that prefills them, pulses start_conv and waits for end_op.
module feeder_fifo #(
   parameter int W  = 64,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [W-1:0]  push_data,
   input  logic          push_valid,
   output logic          push_ready,
   input  logic          read,
   output logic [W-1:0]  head,
   output logic [AW:0]   level,
   output logic          underflow
);
   localparam int DEPTH = 2 ** AW;
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   assign push_ready = (level != FULL_LEVEL);
   assign push       = push_valid && push_ready;
   assign pop        = read && (level != '0);
   assign underflow  = read && (level == '0);
   assign head       = (level != '0) ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage needs no reset: head is masked to zero whenever level is zero.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end
endmodule

module conv_operand_feeder #(
   parameter int IFM_W       = 64,
   parameter int WGT_W       = 32,
   parameter int AW          = 4,
   parameter int IFM_PREFILL = 8,
   parameter int WGT_PREFILL = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   conv_operand_feeder_if.slave  bus,
   input  logic                  go,
   input  logic                  end_op,
   output logic                  start_conv,
   output logic                  busy,
   output logic                  done,
   output logic                  underflow_err,
   output logic [AW:0]           ifm_level,
   output logic [AW:0]           wgt_level
);
   localparam logic [AW:0] IFM_THR = (AW+1)'(IFM_PREFILL);
   localparam logic [AW:0] WGT_THR = (AW+1)'(WGT_PREFILL);

   typedef enum logic [1:0] {IDLE, PREFILL, START, RUN} state_t;

   state_t state_q;
   state_t state_d;
   logic   start_d;
   logic   done_d;
   logic   clear_err;
   logic   ifm_under;
   logic   wgt_under;

   feeder_fifo #(.W(IFM_W), .AW(AW)) u_ifm_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_data  (bus.host_ifm_data),
      .push_valid (bus.host_ifm_valid),
      .push_ready (bus.host_ifm_ready),
      .read       (bus.ifm_read),
      .head       (bus.ifm),
      .level      (ifm_level),
      .underflow  (ifm_under)
   );

   feeder_fifo #(.W(WGT_W), .AW(AW)) u_wgt_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_data  (bus.host_wgt_data),
      .push_valid (bus.host_wgt_valid),
      .push_ready (bus.host_wgt_ready),
      .read       (bus.wgt_read),
      .head       (bus.weight),
      .level      (wgt_level),
      .underflow  (wgt_under)
   );

   // An underflow in the same cycle as a clearing go still sets the flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         start_conv    <= 1'b0;
         done          <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_conv <= start_d;
         done       <= done_d;
         if (ifm_under || wgt_under) underflow_err <= 1'b1;
         else if (clear_err)         underflow_err <= 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (go) state_d = PREFILL;
         PREFILL: if (ifm_level >= IFM_THR && wgt_level >= WGT_THR) state_d = START;
         START:   state_d = RUN;
         RUN:     if (end_op) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      start_d   = (state_d == START);
      done_d    = (state_q == RUN) && end_op;
      clear_err = (state_q == IDLE) && go;
      busy      = (state_q != IDLE);
   end
endmodule

// File: tb/tb_conv_operand_feeder.sv
// Scoreboarded bench for conv_operand_feeder: queues model both FIFOs,
// directed vectors exercise the job sequencer and corner cases.
module tb_conv_operand_feeder;
   logic       clk;
   logic       rst_n;
   logic       go;
   logic       end_op;
   logic       start_conv;
   logic       busy;
   logic       done;
   logic       underflow_err;
   logic [4:0] ifm_level;
   logic [4:0] wgt_level;

   int checks   = 0;
   int failures = 0;

   logic [63:0] ifm_q[$];
   logic [31:0] wgt_q[$];

   conv_operand_feeder_if #(.IFM_W(64), .WGT_W(32)) bus ();

   conv_operand_feeder #(
      .IFM_W(64), .WGT_W(32), .AW(4), .IFM_PREFILL(8), .WGT_PREFILL(8)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .go            (go),
      .end_op        (end_op),
      .start_conv    (start_conv),
      .busy          (busy),
      .done          (done),
      .underflow_err (underflow_err),
      .ifm_level     (ifm_level),
      .wgt_level     (wgt_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after a rising edge and are sampled at the next one.
   task automatic applyStimulus(input logic iv, input logic [63:0] id,
                                input logic wv, input logic [31:0] wd,
                                input logic ir, input logic wr,
                                input logic g,  input logic e);
      @(posedge clk);
      #1;
      bus.host_ifm_valid = iv;
      bus.host_ifm_data  = id;
      bus.host_wgt_valid = wv;
      bus.host_wgt_data  = wd;
      bus.ifm_read       = ir;
      bus.wgt_read       = wr;
      go                 = g;
      end_op             = e;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: heads, levels and ready against the queue model, then advance the model.
   always @(negedge clk) begin
      logic ifm_acc;
      logic wgt_acc;
      if (!rst_n) begin
         ifm_q.delete();
         wgt_q.delete();
      end else begin
         checkOutput("ifm_head", bus.ifm, (ifm_q.size() != 0) ? ifm_q[0] : 64'h0);
         checkOutput("wgt_head", {32'h0, bus.weight}, (wgt_q.size() != 0) ? {32'h0, wgt_q[0]} : 64'h0);
         checkOutput("ifm_level", {59'h0, ifm_level}, 64'(ifm_q.size()));
         checkOutput("wgt_level", {59'h0, wgt_level}, 64'(wgt_q.size()));
         checkOutput("ifm_ready", {63'h0, bus.host_ifm_ready}, {63'h0, ifm_q.size() < 16});
         checkOutput("wgt_ready", {63'h0, bus.host_wgt_ready}, {63'h0, wgt_q.size() < 16});
         ifm_acc = bus.host_ifm_valid && (ifm_q.size() < 16);
         wgt_acc = bus.host_wgt_valid && (wgt_q.size() < 16);
         if (bus.ifm_read && ifm_q.size() != 0) void'(ifm_q.pop_front());
         if (bus.wgt_read && wgt_q.size() != 0) void'(wgt_q.pop_front());
         if (ifm_acc) ifm_q.push_back(bus.host_ifm_data);
         if (wgt_acc) wgt_q.push_back(bus.host_wgt_data);
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bus.host_ifm_valid = 1'b0; bus.host_ifm_data = '0;
      bus.host_wgt_valid = 1'b0; bus.host_wgt_data = '0;
      bus.ifm_read = 1'b0; bus.wgt_read = 1'b0;
      go = 1'b0; end_op = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_busy",   {63'h0, busy}, 64'h0);
      checkOutput("rst_start",  {63'h0, start_conv}, 64'h0);
      checkOutput("rst_done",   {63'h0, done}, 64'h0);
      checkOutput("rst_uf",     {63'h0, underflow_err}, 64'h0);
      checkOutput("rst_ifm",    bus.ifm, 64'h0);
      checkOutput("rst_wgt",    {32'h0, bus.weight}, 64'h0);
      checkOutput("rst_irdy",   {63'h0, bus.host_ifm_ready}, 64'h1);
      checkOutput("rst_wrdy",   {63'h0, bus.host_wgt_ready}, 64'h1);
      rst_n = 1'b1;

      // Prefill both FIFOs with 8 words and launch a job.
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b1, 64'hA5A5_0000_0000_0000 + 64'(i), 1'b1, 32'h5A00_0000 + 32'(i),
                       1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("t1_ilvl8",  {59'h0, ifm_level}, 64'd8);
      checkOutput("t1_wlvl8",  {59'h0, wgt_level}, 64'd8);
      checkOutput("t1_idle",   {63'h0, busy}, 64'h0);
      idle();
      checkOutput("t1_busy",   {63'h0, busy}, 64'h1);
      checkOutput("t1_nostart",{63'h0, start_conv}, 64'h0);
      idle();
      checkOutput("t1_start",  {63'h0, start_conv}, 64'h1);
      idle();
      checkOutput("t1_start_off", {63'h0, start_conv}, 64'h0);
      checkOutput("t1_run_busy",  {63'h0, busy}, 64'h1);

      // go in RUN is ignored; end_op ends the job with a one-cycle done.
      applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle();
      checkOutput("t5_go_run_busy", {63'h0, busy}, 64'h1);
      checkOutput("t5_go_run_done", {63'h0, done}, 64'h0);
      applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
      checkOutput("t5_done",     {63'h0, done}, 64'h1);
      checkOutput("t5_not_busy", {63'h0, busy}, 64'h0);
      idle();
      checkOutput("t5_done_off", {63'h0, done}, 64'h0);

      for (int i = 0; i < 8; i++)
         applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle();
      checkOutput("drain_uf", {63'h0, underflow_err}, 64'h0);

      // Empty FIFOs: go parks in PREFILL, where end_op must be ignored.
      applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
      idle();
      checkOutput("t5_pre_busy", {63'h0, busy}, 64'h1);
      checkOutput("t5_pre_done", {63'h0, done}, 64'h0);

      // Two IFM words, then two reads.
      applyStimulus(1'b1, 64'h0807060504030201, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'h1817161514131211, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      checkOutput("t2_w0",   bus.ifm, 64'h0807060504030201);
      checkOutput("t2_lvl2", {59'h0, ifm_level}, 64'd2);
      applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
      checkOutput("t2_w1",   bus.ifm, 64'h1817161514131211);
      checkOutput("t2_lvl1", {59'h0, ifm_level}, 64'd1);
      applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
      checkOutput("t2_empty", bus.ifm, 64'h0);
      checkOutput("t2_lvl0",  {59'h0, ifm_level}, 64'd0);
      checkOutput("t2_uf",    {63'h0, underflow_err}, 64'h0);

      // Fill to 16, extra push dropped, read+push at full nets one pop.
      for (int i = 0; i < 16; i++)
         applyStimulus(1'b1, 64'hB000_0000_0000_0000 + 64'(i), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'hDEAD, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t3_full_lvl", {59'h0, ifm_level}, 64'd16);
      checkOutput("t3_not_rdy",  {63'h0, bus.host_ifm_ready}, 64'h0);
      applyStimulus(1'b1, 64'hBEEF, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t3_drop_lvl", {59'h0, ifm_level}, 64'd16);
      idle();
      checkOutput("t3_lvl15", {59'h0, ifm_level}, 64'd15);
      checkOutput("t3_rdy",   {63'h0, bus.host_ifm_ready}, 64'h1);
      for (int i = 0; i < 15; i++)
         applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
      checkOutput("t3_drained", {59'h0, ifm_level}, 64'd0);

      // Read on empty with a same-cycle push.
      applyStimulus(1'b1, 64'hAA, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
      checkOutput("t4_uf",  {63'h0, underflow_err}, 64'h1);
      checkOutput("t4_lvl", {59'h0, ifm_level}, 64'd1);
      checkOutput("t4_ifm", bus.ifm, 64'hAA);

      // Complete the parked job, then go from IDLE clears the flag.
      for (int i = 0; i < 8; i++)
         applyStimulus(i < 7, 64'hC000_0000_0000_0000 + 64'(i), 1'b1, 32'hC100_0000 + 32'(i),
                       1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) idle();
      checkOutput("t4_run", {63'h0, busy}, 64'h1);
      applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
      checkOutput("t4_done", {63'h0, done}, 64'h1);
      checkOutput("t4_uf_held", {63'h0, underflow_err}, 64'h1);
      applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle();
      checkOutput("t4_uf_clr",  {63'h0, underflow_err}, 64'h0);
      checkOutput("t4_go_busy", {63'h0, busy}, 64'h1);

      // Reach RUN with levels 5/3, then async reset mid-cycle.
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, i < 3, 1'b1, 1'b0, 1'b0);
      idle();
      checkOutput("t6_ilvl5", {59'h0, ifm_level}, 64'd5);
      checkOutput("t6_wlvl3", {59'h0, wgt_level}, 64'd3);
      checkOutput("t6_busy",  {63'h0, busy}, 64'h1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_ilvl0",  {59'h0, ifm_level}, 64'd0);
      checkOutput("t6_wlvl0",  {59'h0, wgt_level}, 64'd0);
      checkOutput("t6_nbusy",  {63'h0, busy}, 64'h0);
      checkOutput("t6_ifm0",   bus.ifm, 64'h0);
      checkOutput("t6_start0", {63'h0, start_conv}, 64'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
